// File: rtl/clock_set_ctrl.sv
// Mode/set controller for a clock: cycles RUN -> SET_HR -> SET_MIN -> SET_SEC on mode presses and emits increment strobes.
// Latency: every output is registered and reflects the inputs sampled at the previous sig_1Hz rising edge.
// Backpressure: none; the buttons are sampled every cycle and the strobes are fire-and-forget.
//
// Ports:
//   sig_1Hz    block clock, all state moves on its rising edge
//   reset      synchronous, active-high
//   mode_btn   mode button level (already synchronous)
//   inc_btn    increment button level (already synchronous)
//   run_en     1 while the seconds counter free-runs (RUN only)
//   hr_b       one-cycle hour increment strobe
//   min_b      one-cycle minute increment strobe
//   sec_clr    one-cycle seconds clear strobe
//   mode_state current mode: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC
//   blink      blink enable for the field being set
module clock_set_ctrl #(
  parameter int unsigned TIMEOUT      = 30,  // idle cycles in a set mode before returning to RUN (1-63)
  parameter int unsigned REPEAT_DELAY = 2    // hold cycles before auto-repeat starts (1-7)
) (
  input  logic       sig_1Hz,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic       run_en,
  output logic       hr_b,
  output logic       min_b,
  output logic       sec_clr,
  output logic [1:0] mode_state,
  output logic       blink
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] SET_HR  = 2'd1;
  localparam logic [1:0] SET_MIN = 2'd2;
  localparam logic [1:0] SET_SEC = 2'd3;

  localparam logic [2:0] RPT_TH  = 3'(REPEAT_DELAY);
  localparam logic [5:0] IDLE_LAST = 6'(TIMEOUT - 1);

  logic [1:0] state;
  logic [1:0] next_state;
  logic       mode_q;
  logic       inc_q;
  logic [2:0] hold_cnt;
  logic [2:0] next_hold;
  logic [5:0] idle_cnt;
  logic [5:0] next_idle;

  logic mode_edge;
  logic inc_edge;
  logic set_mode;
  logic repeat_ok;
  logic strobe_cond;
  logic fire;
  logic timeout;

  always_comb begin
    mode_edge = mode_btn & ~mode_q;
    inc_edge  = inc_btn & ~inc_q;
    set_mode  = (state != RUN);
    repeat_ok = inc_btn & inc_q & (hold_cnt >= RPT_TH);
    // Auto-repeat applies to hours and minutes only; seconds clear is edge-only.
    strobe_cond = set_mode & (inc_edge | (repeat_ok & (state != SET_SEC)));
    // A mode change in the same cycle swallows the strobe.
    fire = strobe_cond & ~mode_edge;
    // inc_btn=1 or a mode edge would have cleared idle_cnt, so no timeout then.
    timeout = set_mode & ~mode_edge & ~inc_btn & (idle_cnt == IDLE_LAST);
  end

  always_comb begin
    next_state = state;
    if (mode_edge) begin
      case (state)
        RUN:     next_state = SET_HR;
        SET_HR:  next_state = SET_MIN;
        SET_MIN: next_state = SET_SEC;
        default: next_state = RUN;
      endcase
    end else if (timeout) begin
      next_state = RUN;
    end
  end

  always_comb begin
    next_hold = hold_cnt;
    if (!inc_btn) begin
      next_hold = 3'd0;
    end else if (mode_edge && strobe_cond) begin
      next_hold = 3'd0;
    end else if (inc_q && (hold_cnt != 3'd7)) begin
      next_hold = hold_cnt + 3'd1;
    end
  end

  always_comb begin
    next_idle = idle_cnt + 6'd1;
    if (mode_edge || inc_btn || !set_mode || timeout) begin
      next_idle = 6'd0;
    end
  end

  always_ff @(posedge sig_1Hz) begin
    if (reset) begin
      state    <= RUN;
      run_en   <= 1'b1;
      hr_b     <= 1'b0;
      min_b    <= 1'b0;
      sec_clr  <= 1'b0;
      blink    <= 1'b0;
      mode_q   <= 1'b0;
      inc_q    <= 1'b0;
      hold_cnt <= 3'd0;
      idle_cnt <= 6'd0;
    end else begin
      state    <= next_state;
      run_en   <= (next_state == RUN);
      hr_b     <= fire & (state == SET_HR);
      min_b    <= fire & (state == SET_MIN);
      sec_clr  <= fire & (state == SET_SEC);
      // Entering a set mode starts the blink phase at 1; it then alternates.
      if (next_state == RUN) begin
        blink <= 1'b0;
      end else if (!set_mode) begin
        blink <= 1'b1;
      end else begin
        blink <= ~blink;
      end
      mode_q   <= mode_btn;
      inc_q    <= inc_btn;
      hold_cnt <= next_hold;
      idle_cnt <= next_idle;
    end
  end

  assign mode_state = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with a queue scoreboard.
// Each stimulus cycle pushes the hand-computed outputs expected after the next clock edge.
// A monitor pops one entry per clock edge and compares all outputs.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       run_en;
  logic       hr_b;
  logic       min_b;
  logic       sec_clr;
  logic [1:0] mode_state;
  logic       blink;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_q[$];
  string      name_q[$];

  clock_set_ctrl #(.TIMEOUT(30), .REPEAT_DELAY(2)) dut (
    .sig_1Hz    (clk),
    .reset      (reset),
    .mode_btn   (mode_btn),
    .inc_btn    (inc_btn),
    .run_en     (run_en),
    .hr_b       (hr_b),
    .min_b      (min_b),
    .sec_clr    (sec_clr),
    .mode_state (mode_state),
    .blink      (blink)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the following edge.
  task automatic cyc(input logic r, input logic m, input logic i,
                     input logic e_run, input logic [1:0] e_ms,
                     input logic e_hr, input logic e_mn, input logic e_sc,
                     input logic e_bl, input string nm);
    @(negedge clk);
    reset    = r;
    mode_btn = m;
    inc_btn  = i;
    exp_q.push_back({e_run, e_ms, e_hr, e_mn, e_sc, e_bl});
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are valid every cycle, so compare once per edge while expectations are pending.
  initial begin
    logic [6:0] e;
    logic [6:0] a;
    string      n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = {run_en, mode_state, hr_b, min_b, sec_clr, blink};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: run_en/mode/hr/min/sec/blink got %b_%b_%b%b%b_%b want %b_%b_%b%b%b_%b",
                   n, a[6], a[5:4], a[3], a[2], a[1], a[0], e[6], e[5:4], e[3], e[2], e[1], e[0]);
        end
        checks++;
        if ($countones({hr_b, min_b, sec_clr}) > 1) begin
          errors++;
          $display("FAIL %s_onehot: strobes hr/min/sec got %b%b%b want at most one high",
                   n, hr_b, min_b, sec_clr);
        end
      end
    end
  end

  initial begin
    // Reset state
    cyc(1, 0, 0, 1, 2'd0, 0, 0, 0, 0, "reset0");
    cyc(1, 0, 0, 1, 2'd0, 0, 0, 0, 0, "reset1");

    // Four mode pulses, two cycles apart
    cyc(0, 1, 0, 0, 2'd1, 0, 0, 0, 1, "mode_to_hr");
    cyc(0, 0, 0, 0, 2'd1, 0, 0, 0, 0, "hr_gap");
    cyc(0, 1, 0, 0, 2'd2, 0, 0, 0, 1, "mode_to_min");
    cyc(0, 0, 0, 0, 2'd2, 0, 0, 0, 0, "min_gap");
    cyc(0, 1, 0, 0, 2'd3, 0, 0, 0, 1, "mode_to_sec");
    cyc(0, 0, 0, 0, 2'd3, 0, 0, 0, 0, "sec_gap");
    cyc(0, 1, 0, 1, 2'd0, 0, 0, 0, 0, "mode_to_run");
    cyc(0, 0, 0, 1, 2'd0, 0, 0, 0, 0, "run_gap");

    // SET_MIN auto-repeat: strobe at hold cycles 1,4,5,6
    cyc(0, 1, 0, 0, 2'd1, 0, 0, 0, 1, "rpt_enter_hr");
    cyc(0, 0, 0, 0, 2'd1, 0, 0, 0, 0, "rpt_gap");
    cyc(0, 1, 0, 0, 2'd2, 0, 0, 0, 1, "rpt_enter_min");
    cyc(0, 0, 1, 0, 2'd2, 0, 1, 0, 0, "rpt_c1");
    cyc(0, 0, 1, 0, 2'd2, 0, 0, 0, 1, "rpt_c2");
    cyc(0, 0, 1, 0, 2'd2, 0, 0, 0, 0, "rpt_c3");
    cyc(0, 0, 1, 0, 2'd2, 0, 1, 0, 1, "rpt_c4");
    cyc(0, 0, 1, 0, 2'd2, 0, 1, 0, 0, "rpt_c5");
    cyc(0, 0, 1, 0, 2'd2, 0, 1, 0, 1, "rpt_c6");
    cyc(0, 0, 0, 0, 2'd2, 0, 0, 0, 0, "rpt_release");

    // SET_SEC: one sec_clr only, no repeat
    cyc(0, 1, 0, 0, 2'd3, 0, 0, 0, 1, "sec_enter");
    cyc(0, 0, 1, 0, 2'd3, 0, 0, 1, 0, "sec_c1");
    cyc(0, 0, 1, 0, 2'd3, 0, 0, 0, 1, "sec_c2");
    cyc(0, 0, 1, 0, 2'd3, 0, 0, 0, 0, "sec_c3");
    cyc(0, 0, 1, 0, 2'd3, 0, 0, 0, 1, "sec_c4");
    cyc(0, 0, 1, 0, 2'd3, 0, 0, 0, 0, "sec_c5");
    cyc(0, 0, 0, 0, 2'd3, 0, 0, 0, 1, "sec_release");
    cyc(0, 1, 0, 1, 2'd0, 0, 0, 0, 0, "sec_to_run");

    // RUN ignores inc_btn
    cyc(0, 0, 1, 1, 2'd0, 0, 0, 0, 0, "run_inc");
    cyc(0, 0, 0, 1, 2'd0, 0, 0, 0, 0, "run_inc_rel");

    // Timeout: 30 idle edges in SET_HR return to RUN at the 30th
    cyc(0, 1, 0, 0, 2'd1, 0, 0, 0, 1, "to_enter_hr");
    for (int k = 1; k < 30; k++) begin
      cyc(0, 0, 0, 0, 2'd1, 0, 0, 0, 1'((k % 2) == 0), $sformatf("to_idle_%0d", k));
    end
    cyc(0, 0, 0, 1, 2'd0, 0, 0, 0, 0, "to_expire");
    cyc(0, 0, 0, 1, 2'd0, 0, 0, 0, 0, "to_after");

    // Simultaneous mode and inc edges in SET_HR: mode wins, no strobe
    cyc(0, 1, 0, 0, 2'd1, 0, 0, 0, 1, "sim_enter_hr");
    cyc(0, 0, 0, 0, 2'd1, 0, 0, 0, 0, "sim_gap");
    cyc(0, 1, 1, 0, 2'd2, 0, 0, 0, 1, "sim_both");
    cyc(0, 0, 0, 0, 2'd2, 0, 0, 0, 0, "sim_after");
    cyc(0, 0, 1, 0, 2'd2, 0, 1, 0, 1, "sim_min_inc");
    cyc(0, 0, 0, 0, 2'd2, 0, 0, 0, 0, "sim_min_rel");

    // Reset during an active auto-repeat in SET_MIN
    cyc(0, 0, 1, 0, 2'd2, 0, 1, 0, 1, "rr_c1");
    cyc(0, 0, 1, 0, 2'd2, 0, 0, 0, 0, "rr_c2");
    cyc(0, 0, 1, 0, 2'd2, 0, 0, 0, 1, "rr_c3");
    cyc(0, 0, 1, 0, 2'd2, 0, 1, 0, 0, "rr_c4");
    cyc(1, 0, 1, 1, 2'd0, 0, 0, 0, 0, "rr_reset");
    cyc(0, 0, 1, 1, 2'd0, 0, 0, 0, 0, "rr_held1");
    cyc(0, 0, 1, 1, 2'd0, 0, 0, 0, 0, "rr_held2");
    cyc(0, 0, 0, 1, 2'd0, 0, 0, 0, 0, "rr_drop");
    cyc(0, 1, 0, 0, 2'd1, 0, 0, 0, 1, "rr_enter_hr");
    cyc(0, 0, 0, 0, 2'd1, 0, 0, 0, 0, "rr_gap1");
    cyc(0, 1, 0, 0, 2'd2, 0, 0, 0, 1, "rr_enter_min");
    cyc(0, 0, 0, 0, 2'd2, 0, 0, 0, 0, "rr_gap2");
    cyc(0, 0, 1, 0, 2'd2, 0, 1, 0, 1, "rr_refire");
    cyc(0, 0, 0, 0, 2'd2, 0, 0, 0, 0, "rr_refire_rel");

    // mode_btn held through reset registers as an edge after release
    cyc(1, 1, 0, 1, 2'd0, 0, 0, 0, 0, "hold_reset");
    cyc(0, 1, 0, 0, 2'd1, 0, 0, 0, 1, "hold_release");
    cyc(0, 0, 0, 0, 2'd1, 0, 0, 0, 0, "hold_drop");

    // hr_b strobe in SET_HR
    cyc(0, 0, 1, 0, 2'd1, 1, 0, 0, 1, "hr_inc");
    cyc(0, 0, 0, 0, 2'd1, 0, 0, 0, 0, "hr_inc_rel");
    cyc(1, 0, 0, 1, 2'd0, 0, 0, 0, 0, "final_reset");

    // Let the monitor drain the scoreboard, with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending expectations got %0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
